pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline register for the 5-stage core. Replaces the fixed if_id / id_ex / ex_mem / mem_wb style registers.
- Carries a DATA_W-bit payload between any two stages with valid/ready flow control, per-stage flush and an optional skid buffer for full throughput under back-pressure.
- Flushed or empty slots emit a configurable bubble value (NOP).
- Exposes a saturating stall-cycle counter for performance debug.

Parameters:
- DATA_W, 64, payload width in bits (concatenated stage fields).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- BUBBLE, {DATA_W{1'b0}}, value driven on out_data when the stage is empty or flushed.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream presents data.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage accepts in_data this cycle.
- out_valid  out  1  out_data is valid.
- out_data  out  DATA_W  payload to downstream.
- out_ready  in  1  downstream accepts this cycle.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= EMPTY; out_valid <= 0; out_data <= BUBBLE; stall_cnt <= 0.
  - in_ready is 1 in the cycle after reset.
  - rst has priority over flush and over all handshakes.
- Transfer rules:
  - Input transfer occurs on an edge where in_valid & in_ready.
  - Output transfer occurs on an edge where out_valid & out_ready.
  - out_data and out_valid are driven only from registers, so there is no combinational in→out path.
- States (SKID=1): EMPTY (no entries), ONE (main reg holds data), TWO (main + skid hold data).
  - EMPTY: in_valid → ONE, main <= in_data.
  - ONE: in_valid & out_ready → ONE, main <= in_data.
  - ONE: in_valid & !out_ready → TWO, skid <= in_data.
  - ONE: !in_valid & out_ready → EMPTY.
  - ONE: otherwise hold.
  - TWO: out_ready → ONE, main <= skid.
  - TWO: otherwise hold.
  - in_ready is registered and equals (next_state != TWO).
  - Throughput is 1 beat/cycle; latency in→out is 1 cycle.
- SKID=0: states EMPTY and ONE only. in_ready = !out_valid | out_ready (combinational); otherwise the same transitions apply.
- out_valid = (state != EMPTY).
- out_data = main when valid, BUBBLE when EMPTY. Once a beat is presented, out_data must be stable until it is accepted.
- Flush:
  - On an edge with flush=1 (and rst=0): state <= EMPTY, out_data <= BUBBLE.
  - Any input transfer in the same cycle is discarded.
  - An output transfer in the same cycle still counts as consumed downstream.
  - in_ready = 1 the following cycle.
- stall_cnt increments each cycle with out_valid & !out_ready, saturates at 2^CNT_W−1, and is not cleared by flush.
- Ordering: beats leave in the order accepted; no loss, no duplication.

Decomposition:
- Shared package sirius_pipe_pkg holds:
  - state encoding: EMPTY=2'd0, ONE=2'd1, TWO=2'd2;
  - the NOP bubble constant;
  - per-stage DATA_W constants, e.g. IF_ID_W = InstAddr+Inst width.
- No sub-module: the skid is a second register inside the same block, gated by a generate on SKID.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1, in_data=0xA5 → out_valid=0, out_data=BUBBLE, stall_cnt=0; in_ready=1 after release.
- Streaming: SKID=1, out_ready=1, send 0x01..0x08 back-to-back → out_data 0x01..0x08 on consecutive cycles, each 1 cycle after input, in_ready held 1.
- Back-pressure: send 0x10, 0x11, 0x12 with out_ready=0 →
  - 0x10 in main, 0x11 in skid, in_ready=0, 0x12 held upstream;
  - release out_ready → 0x10, 0x11, 0x12 emerge in order;
  - stall_cnt equals the number of stalled cycles.
- Flush: flush=1 while state TWO with in_valid=1, in_data=0x33 → next cycle out_valid=0, out_data=BUBBLE, in_ready=1, and 0x33 never appears.
- SKID=0: out_ready=0 with one beat held → in_ready=0 combinationally; raise out_ready and in_valid together → in_ready=1 in the same cycle and the new beat replaces the old.
- Saturation: CNT_W=4, stall for 20 cycles → stall_cnt=15, held; rst → 0.

Source files
------------

// File: rtl/sirius_pipe_pkg.sv
// sirius_pipe_pkg: shared definitions for the 5-stage core pipeline registers.
//   - stage_state_e : occupancy state of a pipe_stage_reg (EMPTY/ONE/TWO)
//   - NOP_INST      : bubble instruction word (addi x0, x0, 0)
//   - *_W           : payload widths of the inter-stage registers
package sirius_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned CTRL_W      = 16;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  localparam int unsigned IF_ID_W  = INST_ADDR_W + INST_W;
  localparam int unsigned ID_EX_W  = INST_ADDR_W + 2 * XLEN + REG_IDX_W + CTRL_W;
  localparam int unsigned EX_MEM_W = 2 * XLEN + REG_IDX_W + CTRL_W;
  localparam int unsigned MEM_WB_W = XLEN + REG_IDX_W + CTRL_W;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register between two core stages.
//   Parameters: DATA_W payload width, SKID (1 = two-entry skid buffer with
//   registered in_ready, 0 = single register with combinational in_ready),
//   BUBBLE value shown on out_data when empty/flushed, CNT_W stall counter width.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     flush           squash all held entries (input beat in same cycle dropped)
//     in_valid/in_data/in_ready     upstream handshake
//     out_valid/out_data/out_ready  downstream handshake (outputs registered)
//     stall_cnt       saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg
  import sirius_pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = 64,
  parameter int unsigned       SKID   = 1,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q;
  logic [CNT_W-1:0]  stall_q;
  logic              in_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (state_q != EMPTY);
  // main_q is forced to BUBBLE whenever the stage empties, so out_data can
  // come straight from the register without an output mux.
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_xfer && out_ready) begin
          main_d = in_data;
        end else if (in_xfer) begin
          // only reachable with SKID: without it in_ready is low here
          state_d = TWO;
        end else if (out_ready) begin
          state_d = EMPTY;
          main_d  = BUBBLE;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        in_ready_q <= 1'b1;
        skid_q     <= BUBBLE;
      end else begin
        in_ready_q <= (state_d != TWO);
        if ((state_q == ONE) && in_xfer && !out_ready) begin
          skid_q <= in_data;
        end
      end
    end

    assign in_ready = in_ready_q;
  end else begin : g_noskid
    assign skid_q   = BUBBLE;
    assign in_ready = !out_valid || out_ready;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed bench for pipe_stage_reg.
//   dut_a: SKID=1, DATA_W=8, CNT_W=16, BUBBLE=8'hEE
//   dut_b: SKID=0, DATA_W=8, CNT_W=4,  BUBBLE=8'hEE
module tb_pipe_stage_reg;

  localparam logic [7:0] BUB = 8'hEE;

  logic clk = 1'b0;
  logic rst, flush;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0]  a_in_data, a_out_data;
  logic [15:0] a_stall;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_data, b_out_data;
  logic [3:0]  b_stall;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .BUBBLE(BUB), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .stall_cnt(a_stall)
  );

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .BUBBLE(BUB), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .stall_cnt(b_stall)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA5; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b1;

    // reset held two cycles with a beat offered
    tick(); tick();
    check_eq("rst_a_valid", a_out_valid, 0);
    check_eq("rst_a_data",  a_out_data,  BUB);
    check_eq("rst_a_stall", a_stall,     0);
    check_eq("rst_a_ready", a_in_ready,  1);
    check_eq("rst_b_valid", b_out_valid, 0);
    check_eq("rst_b_data",  b_out_data,  BUB);
    check_eq("rst_b_stall", b_stall,     0);
    rst = 1'b0; a_in_valid = 1'b0;
    #1;
    check_eq("post_rst_a_ready", a_in_ready, 1);
    check_eq("post_rst_b_ready", b_in_ready, 1);

    // streaming 0x01..0x08 with out_ready=1
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 8'(i);
      tick();
      check_eq("stream_valid", a_out_valid, 1);
      check_eq("stream_data",  a_out_data,  32'(i));
      check_eq("stream_ready", a_in_ready,  1);
    end
    a_in_valid = 1'b0;
    tick();
    check_eq("stream_drain_valid", a_out_valid, 0);
    check_eq("stream_drain_data",  a_out_data,  BUB);
    check_eq("stream_stall",       a_stall,     0);

    // back-pressure: 0x10 main, 0x11 skid, 0x12 held upstream
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h10;
    tick();
    check_eq("bp_main_10", a_out_data, 8'h10);
    check_eq("bp_ready_1", a_in_ready, 1);
    a_in_data = 8'h11;
    tick();
    check_eq("bp_ready_0", a_in_ready, 0);
    check_eq("bp_hold_10", a_out_data, 8'h10);
    a_in_data = 8'h12;
    tick();
    check_eq("bp_hold2_10", a_out_data, 8'h10);
    check_eq("bp_ready_0b", a_in_ready, 0);
    tick();
    check_eq("bp_stall3", a_stall, 3);
    a_out_ready = 1'b1;
    tick();
    check_eq("bp_out_11",   a_out_data, 8'h11);
    check_eq("bp_ready_up", a_in_ready, 1);
    tick();
    check_eq("bp_out_12",   a_out_data, 8'h12);
    check_eq("bp_valid_12", a_out_valid, 1);
    a_in_valid = 1'b0;
    tick();
    check_eq("bp_empty",       a_out_valid, 0);
    check_eq("bp_stall_final", a_stall,     3);

    // flush while TWO with 0x33 offered
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h20;
    tick();
    a_in_data = 8'h21;
    tick();
    check_eq("fl_two_ready", a_in_ready, 0);
    flush = 1'b1; a_in_data = 8'h33;
    tick();
    check_eq("fl_valid", a_out_valid, 0);
    check_eq("fl_data",  a_out_data,  BUB);
    check_eq("fl_ready", a_in_ready,  1);
    check_eq("fl_stall", a_stall,     5);
    // flush while empty with an accepted beat: beat must be dropped
    a_in_data = 8'h34;
    tick();
    check_eq("fl2_valid", a_out_valid, 0);
    flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    tick();
    check_eq("fl3_valid", a_out_valid, 0);
    check_eq("fl3_data",  a_out_data,  BUB);

    // SKID=0: combinational in_ready and replace-on-accept
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 8'h40;
    #1;
    check_eq("ns_ready_empty", b_in_ready, 1);
    tick();
    check_eq("ns_data_40", b_out_data, 8'h40);
    check_eq("ns_ready_0", b_in_ready, 0);
    b_in_data = 8'h41;
    b_out_ready = 1'b1;
    #1;
    check_eq("ns_ready_comb", b_in_ready, 1);
    tick();
    check_eq("ns_data_41",  b_out_data,  8'h41);
    check_eq("ns_valid_41", b_out_valid, 1);
    check_eq("ns_stall_0",  b_stall,     0);

    // saturation: 20 stalled cycles on a 4-bit counter
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check_eq("sat_15",      b_stall,    15);
    check_eq("sat_hold_41", b_out_data, 8'h41);
    tick();
    check_eq("sat_held",    b_stall,    15);
    rst = 1'b1;
    tick();
    check_eq("sat_rst",       b_stall,     0);
    check_eq("sat_rst_valid", b_out_valid, 0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
